// File: rtl/spio_aer_pkg.sv
// spio_aer_pkg: shared FSM encodings, SpiNNaker key bounds and saturating increment
package spio_aer_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_REL  = 2'd2;
  localparam int KEY_HI = 39;
  localparam int KEY_LO = 8;
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] top;
    top = 32'hFFFF_FFFF >> (32 - w);
    return (v == top) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/spio_aer_fifo.sv
// spio_aer_fifo: synchronous event FIFO with registered read data
module spio_aer_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_cnt;
  logic          w_push, w_pop;
  assign full   = r_cnt == (AW+1)'(DEPTH);
  assign empty  = r_cnt == '0;
  assign count  = r_cnt;
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      dout  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= din;
        r_wp        <= r_wp + 1'b1;
      end
      if (w_pop) begin
        dout <= r_mem[r_rp];
        r_rp <= r_rp + 1'b1;
      end
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
endmodule

// File: rtl/spio_spinn2aer_mapper_gen.sv
// spio_spinn2aer_mapper_gen: key-filtered SpiNNaker packet to 4-phase active-low AER mapper
module spio_spinn2aer_mapper_gen
  import spio_aer_pkg::*;
#(
  parameter int PKT_BITS    = 72,
  parameter int AER_BITS    = 16,
  parameter int KEY_LSB     = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int ACK_TIMEOUT = 1023,
  parameter int CNT_BITS    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PKT_BITS-1:0] opkt_data,
  input  logic                opkt_vld,
  output logic                opkt_rdy,
  input  logic [31:0]         cfg_key_mask,
  input  logic [31:0]         cfg_key_match,
  output logic [AER_BITS-1:0] oaer_data,
  output logic                oaer_req,
  input  logic                oaer_ack,
  output logic [CNT_BITS-1:0] sent_cnt,
  output logic [CNT_BITS-1:0] filt_cnt,
  output logic [CNT_BITS-1:0] tout_cnt
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] TO_LAST = 32'(ACK_TIMEOUT - 1);
  logic                r_ack_m, r_ack_s, r_en, r_req;
  logic [1:0]          r_state;
  logic [31:0]         r_wait;
  logic [CNT_BITS-1:0] r_sent, r_filt, r_tout;
  logic [CW-1:0]       w_count;
  logic [AER_BITS-1:0] w_dout;
  logic                w_full, w_empty, w_xfer, w_hit, w_pop, w_timeout, w_unused;
  assign w_unused  = ^{opkt_data, w_full};
  assign opkt_rdy  = r_en && !rst && (w_count != CW'(FIFO_DEPTH));
  assign w_xfer    = opkt_vld && opkt_rdy;
  assign w_hit     = (opkt_data[KEY_HI:KEY_LO] & cfg_key_mask) == cfg_key_match;
  assign w_pop     = (r_state == ST_IDLE) && !w_empty && r_ack_s;
  assign w_timeout = (ACK_TIMEOUT != 0) && (r_wait == TO_LAST);
  assign oaer_data = w_dout;
  assign oaer_req  = r_req;
  assign sent_cnt  = r_sent;
  assign filt_cnt  = r_filt;
  assign tout_cnt  = r_tout;
  spio_aer_fifo #(.W(AER_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_xfer && w_hit),
    .din   (opkt_data[KEY_LSB +: AER_BITS]),
    .pop   (w_pop),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ack_m <= 1'b1;
      r_ack_s <= 1'b1;
      r_en    <= 1'b0;
      r_req   <= 1'b1;
      r_state <= ST_IDLE;
      r_wait  <= '0;
      r_sent  <= '0;
      r_filt  <= '0;
      r_tout  <= '0;
    end else begin
      r_en    <= 1'b1;
      r_ack_m <= oaer_ack;
      r_ack_s <= r_ack_m;
      if (w_xfer && !w_hit) r_filt <= CNT_BITS'(sat_inc(32'(r_filt), CNT_BITS));
      case (r_state)
        ST_IDLE: if (w_pop) begin
          r_req   <= 1'b0;
          r_wait  <= '0;
          r_state <= ST_REQ;
        end
        ST_REQ: if (!r_ack_s) begin
          r_req   <= 1'b1;
          r_state <= ST_REL;
        end else if (w_timeout) begin
          r_req   <= 1'b1;
          r_tout  <= CNT_BITS'(sat_inc(32'(r_tout), CNT_BITS));
          r_state <= ST_IDLE;
        end else begin
          r_wait <= r_wait + 32'd1;
        end
        ST_REL: if (r_ack_s) begin
          r_sent  <= CNT_BITS'(sat_inc(32'(r_sent), CNT_BITS));
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spio_spinn2aer_mapper_gen.sv
// tb_spio_spinn2aer_mapper_gen: table-driven and directed checks of the AER mapper
module tb_spio_spinn2aer_mapper_gen;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic [71:0] opkt_data = '0;
  logic        opkt_vld = 1'b0, ack = 1'b1, ack2 = 1'b1;
  logic [31:0] mask = '0, match = '0;
  logic        rdy, req, rdy2, req2;
  logic [15:0] aer_data, aer_data2;
  logic [3:0]  sent, filt, tout;
  logic [15:0] sent2, filt2, tout2;
  int n_chk = 0, n_pass = 0, hold_err = 0;
  int n, base, exp_s, exp_f, dph = 0, dcnt = 0, dev_dly = 3;
  bit dev_en = 0;
  logic        prev_req = 1'b1;
  logic [15:0] prev_data = '0;
  logic [15:0] got[$];
  typedef struct {
    logic [31:0] key;
    logic [31:0] mask;
    logic [31:0] match;
    bit          hit;
  } vec_t;
  vec_t tbl[8];
  spio_spinn2aer_mapper_gen #(.ACK_TIMEOUT(8), .CNT_BITS(4)) dut (
    .clk(clk), .rst(rst), .opkt_data(opkt_data), .opkt_vld(opkt_vld), .opkt_rdy(rdy),
    .cfg_key_mask(mask), .cfg_key_match(match), .oaer_data(aer_data), .oaer_req(req),
    .oaer_ack(ack), .sent_cnt(sent), .filt_cnt(filt), .tout_cnt(tout)
  );
  spio_spinn2aer_mapper_gen #(.ACK_TIMEOUT(0)) dut_nt (
    .clk(clk), .rst(rst), .opkt_data(opkt_data), .opkt_vld(opkt_vld), .opkt_rdy(rdy2),
    .cfg_key_mask(mask), .cfg_key_match(match), .oaer_data(aer_data2), .oaer_req(req2),
    .oaer_ack(ack2), .sent_cnt(sent2), .filt_cnt(filt2), .tout_cnt(tout2)
  );
  function automatic logic [71:0] mk(input logic [31:0] key);
    return {32'hDEAD_BEEF, key, 8'h5A};
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  task automatic tick();
    @(negedge clk);
    if (!prev_req && !req && aer_data != prev_data) hold_err++;
    if (prev_req && !req) got.push_back(aer_data);
    prev_req = req;
    prev_data = aer_data;
    if (dev_en) begin
      if (dph == 0 && !req) begin
        dcnt++;
        if (dcnt >= dev_dly) begin ack = 1'b0; dph = 1; dcnt = 0; end
      end else if (dph == 1 && req) begin
        dcnt++;
        if (dcnt >= dev_dly) begin ack = 1'b1; dph = 0; dcnt = 0; end
      end
    end
  endtask
  task automatic send(input logic [31:0] key);
    bit done;
    done = 0;
    opkt_data = mk(key);
    opkt_vld = 1'b1;
    for (int i = 0; i < 300 && !done; i++) begin
      if (rdy) done = 1;
      tick();
    end
    if (!done) begin
      n_chk++;
      $display("FAIL send_timeout: key %0h never accepted", key);
    end
  endtask
  task automatic wait_cnt(input int es, input int ef, input int et, input string nm);
    for (int i = 0; i < 300; i++) begin
      if (32'(sent) == es && 32'(filt) == ef && 32'(tout) == et) break;
      tick();
    end
    chk({nm, "_sent"}, 32'(sent), es);
    chk({nm, "_filt"}, 32'(filt), ef);
    chk({nm, "_tout"}, 32'(tout), et);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    tbl[0] = '{32'h0000_A5C3, 32'h0000_0000, 32'h0000_0000, 1'b1};
    tbl[1] = '{32'h0001_1234, 32'hFFFF_0000, 32'h0001_0000, 1'b1};
    tbl[2] = '{32'h0002_1234, 32'hFFFF_0000, 32'h0001_0000, 1'b0};
    tbl[3] = '{32'h00FF_0F0F, 32'h00FF_0000, 32'h00FF_0000, 1'b1};
    tbl[4] = '{32'h1234_5678, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1};
    tbl[5] = '{32'h1234_5679, 32'hFFFF_FFFF, 32'h1234_5678, 1'b0};
    tbl[6] = '{32'h8000_0001, 32'h8000_0000, 32'h8000_0000, 1'b1};
    tbl[7] = '{32'h0000_0001, 32'h8000_0000, 32'h8000_0000, 1'b0};
    repeat (2) tick();
    chk("rst_rdy", 32'(rdy), 0);
    chk("rst_req", 32'(req), 1);
    chk("rst_data", 32'(aer_data), 0);
    chk("rst_sent", 32'(sent), 0);
    chk("rst_filt", 32'(filt), 0);
    chk("rst_tout", 32'(tout), 0);
    rst = 1'b0;
    chk("rdy_at_rst_release", 32'(rdy), 0);
    tick();
    chk("rdy_after_rst", 32'(rdy), 1);
    send(32'h0000_A5C3);
    opkt_vld = 1'b0;
    chk("single_req_before_pop", 32'(req), 1);
    tick();
    chk("single_req_low", 32'(req), 0);
    chk("single_data", 32'(aer_data), 32'h0000_A5C3);
    repeat (2) tick();
    ack = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n++;
      if (req) break;
    end
    chk("ack_to_req_rise_cycles", n, 3);
    repeat (3) tick();
    ack = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n++;
      if (sent != 0) break;
    end
    chk("release_to_sent_cycles", n, 3);
    chk("single_sent", 32'(sent), 1);
    chk("single_got_count", got.size(), 1);
    chk("single_got_data", 32'(got[0]), 32'h0000_A5C3);
    exp_s = 1;
    exp_f = 0;
    dph = 0;
    dcnt = 0;
    dev_en = 1;
    foreach (tbl[i]) begin
      mask = tbl[i].mask;
      match = tbl[i].match;
      send(tbl[i].key);
      opkt_vld = 1'b0;
      if (tbl[i].hit) exp_s++;
      else exp_f++;
      wait_cnt(exp_s, exp_f, 0, $sformatf("vec%0d", i));
      if (tbl[i].hit) chk($sformatf("vec%0d_data", i), 32'(got[$]), 32'(tbl[i].key[15:0]));
    end
    chk("table_event_count", got.size(), exp_s);
    mask = '0;
    match = '0;
    dev_dly = 1;
    base = got.size();
    for (int k = 0; k < 5; k++) send(32'h0000_0100 + 32'(k));
    chk("bp_rdy_low_when_full", 32'(rdy), 0);
    send(32'h0000_0105);
    opkt_vld = 1'b0;
    exp_s += 6;
    wait_cnt(exp_s, exp_f, 0, "bp");
    chk("bp_count", got.size(), base + 6);
    for (int k = 0; k < 6 && base + k < got.size(); k++)
      chk($sformatf("bp_order%0d", k), 32'(got[base+k]), 32'h0000_0100 + 32'(k));
    dev_en = 0;
    ack = 1'b1;
    send(32'h0000_0BAD);
    send(32'h0000_0BEE);
    opkt_vld = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!req) n++;
      else if (n > 0) break;
      tick();
    end
    chk("timeout_req_low_cycles", n, 8);
    chk("timeout_tout", 32'(tout), 1);
    for (int i = 0; i < 5; i++) begin
      if (!req) break;
      tick();
    end
    chk("timeout_next_req", 32'(req), 0);
    chk("timeout_next_data", 32'(aer_data), 32'h0000_0BEE);
    wait_cnt(exp_s, exp_f, 2, "timeout2");
    chk("no_timeout_req_held", 32'(req2), 0);
    chk("no_timeout_tout", 32'(tout2), 0);
    chk("no_timeout_sent", 32'(sent2), 0);
    send(32'h0000_0C01);
    send(32'h0000_0C02);
    send(32'h0000_0C03);
    opkt_vld = 1'b0;
    ack = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (req) break;
      tick();
    end
    chk("midrst_in_rel", 32'(req), 1);
    rst = 1'b1;
    #1;
    chk("midrst_rdy_in_rst", 32'(rdy), 0);
    tick();
    rst = 1'b0;
    ack = 1'b1;
    chk("midrst_req", 32'(req), 1);
    chk("midrst_data", 32'(aer_data), 0);
    chk("midrst_sent", 32'(sent), 0);
    chk("midrst_filt", 32'(filt), 0);
    chk("midrst_tout", 32'(tout), 0);
    chk("midrst_rdy_low", 32'(rdy), 0);
    tick();
    chk("midrst_rdy_high", 32'(rdy), 1);
    base = got.size();
    repeat (8) tick();
    chk("midrst_fifo_empty_events", got.size(), base);
    chk("midrst_req_idle", 32'(req), 1);
    mask = 32'hFFFF_FFFF;
    match = '0;
    for (int k = 0; k < 20; k++) begin
      send(32'h0000_1000 + 32'(k));
      if (k == 13) chk("sat_filt14", 32'(filt), 14);
    end
    opkt_vld = 1'b0;
    tick();
    chk("sat_filt_max", 32'(filt), 15);
    chk("sat_sent_zero", 32'(sent), 0);
    chk("data_hold", hold_err, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
